main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
- Memory-side responder for the cache controller's line-transfer interface. Accepts single-cycle mem_read / mem_write line requests and returns ca_resp after a fixed programmable latency.
- Holds a line-granular backing store, so cache writeback and fetch paths can run against realistic memory timing.
- Sits between the cache FSM / datapath and the rest of the memory system. It also serves as the simulation main memory.

Parameters:
- LINE_W, 128, bits per cache line (4 x 32-bit words)
- ADDR_W, 32, byte address width of mem_addr
- DEPTH, 256, number of lines in the backing store (power of 2)
- LATENCY, 4, cycles from accepted request to ca_resp; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  line read request; sampled only in IDLE
- mem_write  in  1  line write request; sampled only in IDLE
- mem_addr  in  ADDR_W  byte address; line index = mem_addr[4 +: log2(DEPTH)], low 4 bits ignored
- mem_wdata  in  LINE_W  write line data; sampled with mem_write
- mem_rdata  out  LINE_W  read line data; valid when ca_resp=1, held until next read response
- ca_resp  out  1  one-cycle completion pulse for the accepted request
- busy  out  1  high while a request is outstanding, including the ca_resp cycle
- proto_err  out  1  one-cycle pulse on illegal request (see below)

Behaviour:
- Reset (async assert, sync use on deassert):
  - state=IDLE, count=0, ca_resp=0, busy=0, proto_err=0, mem_rdata=0.
  - Backing store contents are NOT cleared. The bench preloads them via hierarchical access or writes.
- States: IDLE, RD_WAIT, WR_WAIT, RESP.
- IDLE, on an edge with exactly one request high:
  - Capture index, plus wdata if writing.
  - Set count=LATENCY-1, busy=1.
  - mem_read goes to RD_WAIT; mem_write goes to WR_WAIT.
  - If LATENCY=1, go directly to RESP.
- IDLE, on an edge with mem_read=1 and mem_write=1:
  - Request rejected; stay in IDLE.
  - proto_err=1 next cycle; no store access; no ca_resp.
- RD_WAIT / WR_WAIT: decrement count each edge. When count reaches 1, the next edge goes to RESP.
- RESP: lasts one cycle. ca_resp=1 and busy=1. The next edge returns to IDLE.
- Timing: a request accepted at edge T gives ca_resp=1 in the cycle following edge T+LATENCY-1. That is exactly LATENCY cycles after the request cycle.
- Write commit: the line is written into the store on the edge entering RESP.
- Read capture: mem_rdata is loaded from the store on the edge entering RESP. It reflects any write committed earlier.
- mem_rdata is unchanged by write responses.
- Any mem_read/mem_write high in RD_WAIT, WR_WAIT or RESP:
  - The request is dropped (not queued).
  - proto_err pulses for one cycle per offending cycle.
  - The in-flight transaction is unaffected.
- Requests are pulses. A level held for several cycles from IDLE is accepted once; the remaining cycles raise proto_err.
- Reset mid-transaction: the operation aborts, there is no store write, and ca_resp is never issued.
- Back-to-back operation: a request may be accepted in the cycle after RESP (IDLE). The minimum request spacing is LATENCY+1 cycles.
- Index wrap: address bits above the index field are ignored. For example, 0x0000_1000 and 0x0000_0000 alias when DEPTH=256.

Test Plan:
- Read after preload:
  - Stimulus: line 5 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0BAD_F00D; mem_read pulse with addr 0x50 at cycle 0.
  - Response: ca_resp=1 only in cycle 4; mem_rdata equals that line in cycle 4 and afterwards; busy is high cycles 1-4.
- Write then read:
  - Stimulus: mem_write addr 0x20, wdata 128'h1111...1111; then mem_read addr 0x20 issued in the first IDLE cycle after resp.
  - Response: read returns 128'h1111...1111; responses are 5 cycles apart.
- Illegal requests:
  - Both requests high in IDLE gives proto_err one cycle later, no ca_resp, and no store change.
  - mem_read during WR_WAIT gives a proto_err pulse, and the write still completes on time.
- Reset mid-op:
  - Stimulus: mem_write addr 0x30 data X; rst asserted asynchronously at cycle 2.
  - Response: outputs clear immediately; no ca_resp; a later read of 0x30 returns the old contents.
- LATENCY=1 and wrap:
  - Stimulus: LATENCY=1; mem_read addr 0x1050.
  - Response: ca_resp in the next cycle, returning line 5 (alias of 0x50).

Source files
------------

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if
//   Line-transfer bus between the cache controller and main memory.
//   master : cache side   (drives mem_read/mem_write/mem_addr/mem_wdata)
//   slave  : memory side  (drives mem_rdata/ca_resp/busy/proto_err)
//   Signals:
//     mem_read   request a line read (single-cycle pulse)
//     mem_write  request a line write (single-cycle pulse)
//     mem_addr   byte address; bits [3:0] select a byte inside the line
//     mem_wdata  line to write, valid with mem_write
//     mem_rdata  line read, valid with ca_resp and held until the next read
//     ca_resp    one-cycle completion pulse
//     busy       a request is outstanding (including the ca_resp cycle)
//     proto_err  one-cycle pulse for a request that was not accepted
interface main_mem_responder_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              ca_resp;
    logic              busy;
    logic              proto_err;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, ca_resp, busy, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, ca_resp, busy, proto_err
    );
endinterface

// File: rtl/main_mem_responder.sv
// main_mem_responder
//   Memory-side responder for the cache line-transfer interface. Accepts one
//   line read or write at a time and completes it LATENCY cycles after the
//   request cycle with a one-cycle ca_resp pulse. Holds a line-granular
//   backing store that doubles as the simulation main memory.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  slave side of main_mem_responder_if
//   Parameters:
//     LINE_W   bits per line
//     ADDR_W   byte address width
//     DEPTH    lines in the store (power of 2)
//     LATENCY  request-to-response latency in cycles, 1..15
module main_mem_responder #(
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    main_mem_responder_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESP
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [LINE_W-1:0]  wdata_q,     wdata_d;
    logic [LINE_W-1:0]  rdata_q,     rdata_d;
    logic               ca_resp_q,   ca_resp_d;
    logic               busy_q,      busy_d;
    logic               proto_err_q, proto_err_d;

    logic [LINE_W-1:0]  store [DEPTH];
    logic               store_we;
    logic               rd_load;
    logic [IDX_W-1:0]   store_idx;
    logic [LINE_W-1:0]  store_wdata;

    logic               req_rd;
    logic               req_wr;
    logic [IDX_W-1:0]   req_idx;

    assign req_rd  = bus.mem_read;
    assign req_wr  = bus.mem_write;
    // Upper address bits wrap onto the same lines; the low nibble is the
    // byte offset inside the line.
    assign req_idx = bus.mem_addr[4 +: IDX_W];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[ADDR_W-1:4+IDX_W], bus.mem_addr[3:0]};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        proto_err_d = 1'b0;
        store_we    = 1'b0;
        rd_load     = 1'b0;
        store_idx   = idx_q;
        store_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                proto_err_d = req_rd & req_wr;
                if (req_rd ^ req_wr) begin
                    idx_d   = req_idx;
                    count_d = CNT_W'(LATENCY - 1);
                    if (req_wr) begin
                        wdata_d = bus.mem_wdata;
                    end
                    if (LATENCY == 1) begin
                        // No wait state: the store is accessed on this very
                        // edge, straight from the bus.
                        state_d     = RESP;
                        store_idx   = req_idx;
                        store_wdata = bus.mem_wdata;
                        store_we    = req_wr;
                        rd_load     = req_rd;
                    end else begin
                        state_d = req_rd ? RD_WAIT : WR_WAIT;
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                proto_err_d = req_rd | req_wr;
                if (count_q == CNT_W'(1)) begin
                    state_d  = RESP;
                    store_we = (state_q == WR_WAIT);
                    rd_load  = (state_q == RD_WAIT);
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            RESP: begin
                proto_err_d = req_rd | req_wr;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_load) begin
            rdata_d = store[store_idx];
        end

        // Outputs are registered copies of the next state.
        ca_resp_d = (state_d == RESP);
        busy_d    = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ca_resp_q   <= 1'b0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ca_resp_q   <= ca_resp_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    // NOTE: the store is deliberately not reset; contents survive reset and
    // an array reset would prevent RAM inference. Reset only blocks a commit
    // that would otherwise land on the edge while rst is high.
    always_ff @(posedge clk) begin
        if (store_we && !rst) begin
            store[store_idx] <= store_wdata;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.ca_resp   = ca_resp_q;
    assign bus.busy      = busy_q;
    assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder
//   Drives identical request streams into two responders (LATENCY=4 and
//   LATENCY=1) and compares every cycle against a transaction-level model:
//   an accepted request completes at request_cycle + LATENCY, writes land in
//   a model array at completion, and reads return that array's contents.
module tb_main_mem_responder;
    localparam int LW    = 128;
    localparam int AW    = 32;
    localparam int LINES = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    main_mem_responder_if #(.LINE_W(LW), .ADDR_W(AW)) bus0 ();
    main_mem_responder_if #(.LINE_W(LW), .ADDR_W(AW)) bus1 ();

    main_mem_responder #(.LINE_W(LW), .ADDR_W(AW), .DEPTH(LINES), .LATENCY(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    main_mem_responder #(.LINE_W(LW), .ADDR_W(AW), .DEPTH(LINES), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Reference model state, one slot per DUT.
    logic [LW-1:0] mm [2][LINES];
    bit            pend   [2];
    int            resp_c [2];
    bit            pwr    [2];
    int            pidx   [2];
    logic [LW-1:0] pwd    [2];
    logic [LW-1:0] erd    [2];
    bit            e_resp [2];
    bit            e_busy [2];
    bit            e_perr [2];

    int cyc;
    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            pend[d]   = 1'b0;
            erd[d]    = '0;
            e_resp[d] = 1'b0;
            e_busy[d] = 1'b0;
            e_perr[d] = 1'b0;
        end
    endfunction

    // Inputs present in cycle k; predicts outputs for cycle k+1.
    function automatic void model_step(input int d, input int k, input bit rd, input bit wr,
                                       input logic [AW-1:0] addr, input logic [LW-1:0] wd);
        bit idle;
        int n;
        idle = !pend[d] || (k > resp_c[d]);
        e_perr[d] = idle ? (rd && wr) : (rd || wr);
        if (idle && (rd != wr)) begin
            pend[d]   = 1'b1;
            resp_c[d] = k + lat_of(d);
            pwr[d]    = wr;
            pidx[d]   = int'((addr / 16) % LINES);
            pwd[d]    = wd;
        end
        n = k + 1;
        e_resp[d] = pend[d] && (n == resp_c[d]);
        e_busy[d] = pend[d] && (n <= resp_c[d]);
        if (e_resp[d]) begin
            if (pwr[d]) mm[d][pidx[d]] = pwd[d];
            else        erd[d] = mm[d][pidx[d]];
        end
    endfunction

    task automatic drive(input bit rd, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wd);
        bus0.mem_read  = rd;  bus1.mem_read  = rd;
        bus0.mem_write = wr;  bus1.mem_write = wr;
        bus0.mem_addr  = addr; bus1.mem_addr  = addr;
        bus0.mem_wdata = wd;  bus1.mem_wdata = wd;
    endtask

    task automatic check_outputs();
        check("d0.ca_resp",   {127'd0, bus0.ca_resp},   {127'd0, e_resp[0]});
        check("d0.busy",      {127'd0, bus0.busy},      {127'd0, e_busy[0]});
        check("d0.proto_err", {127'd0, bus0.proto_err}, {127'd0, e_perr[0]});
        check("d0.mem_rdata", bus0.mem_rdata,           erd[0]);
        check("d1.ca_resp",   {127'd0, bus1.ca_resp},   {127'd0, e_resp[1]});
        check("d1.busy",      {127'd0, bus1.busy},      {127'd0, e_busy[1]});
        check("d1.proto_err", {127'd0, bus1.proto_err}, {127'd0, e_perr[1]});
        check("d1.mem_rdata", bus1.mem_rdata,           erd[1]);
    endtask

    // One clock cycle: apply inputs, predict, clock, compare 1 time unit later.
    task automatic step(input bit rd, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wd);
        drive(rd, wr, addr, wd);
        model_step(0, cyc, rd, wr, addr, wd);
        model_step(1, cyc, rd, wr, addr, wd);
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [LW-1:0] LINE5 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0BAD_F00D;
    localparam logic [LW-1:0] ONES  = 128'h1111_1111_1111_1111_1111_1111_1111_1111;

    initial begin
        logic [LW-1:0] ld;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        drive(1'b0, 1'b0, '0, '0);
        model_reset();

        // Reset state.
        #2 rst = 1'b1;
        #1 check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Preload every line through the write path, spaced LATENCY+1 apart.
        for (int i = 0; i < LINES; i++) begin
            ld = (i == 5) ? LINE5 : rand_line();
            step(1'b0, 1'b1, AW'(i * 16 + $urandom_range(0, 15)), ld);
            idle_steps(4);
        end

        // Read after preload.
        step(1'b1, 1'b0, 32'h0000_0050, '0);
        idle_steps(6);

        // Write then read, back to back.
        step(1'b0, 1'b1, 32'h0000_0020, ONES);
        idle_steps(4);
        step(1'b1, 1'b0, 32'h0000_0020, '0);
        idle_steps(4);

        // Both requests in IDLE, then read the targeted line back.
        step(1'b1, 1'b1, 32'h0000_0070, rand_line());
        idle_steps(2);
        step(1'b1, 1'b0, 32'h0000_0070, '0);
        idle_steps(4);

        // Read while a write is in flight.
        step(1'b0, 1'b1, 32'h0000_0040, rand_line());
        step(1'b1, 1'b0, 32'h0000_0060, '0);
        idle_steps(3);
        step(1'b1, 1'b0, 32'h0000_0040, '0);
        idle_steps(4);

        // Held level: accepted once, proto_err on the rest.
        step(1'b1, 1'b0, 32'h0000_0090, '0);
        step(1'b1, 1'b0, 32'h0000_0090, '0);
        step(1'b1, 1'b0, 32'h0000_0090, '0);
        idle_steps(5);

        // Index wrap: 0x1050 aliases line 5.
        step(1'b1, 1'b0, 32'h0000_1050, '0);
        idle_steps(4);

        // Reset mid-write.
        step(1'b0, 1'b1, 32'h0000_0030, rand_line());
        step(1'b0, 1'b0, '0, '0);
        #3 rst = 1'b1;
        model_reset();
        #1 check_outputs();
        @(posedge clk);
        cyc++;
        #1 rst = 1'b0;
        idle_steps(2);
        step(1'b1, 1'b0, 32'h0000_0030, '0);
        idle_steps(4);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            step((r == 0) || (r == 2), (r == 1) || (r == 2), $urandom, rand_line());
        end
        idle_steps(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
